// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single UART transmitter from NREQ byte requesters.
// One transfer at a time: grant, one-cycle launch pulse, then wait for the transmitter to finish.
module uart_tx_arbiter #(
  parameter int NREQ    = 8,
  parameter int BUSY_TO = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] data_in,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic              busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                 state;
  logic [IW-1:0]          ptr;
  logic [IW-1:0]          pick;
  logic                   hit;
  logic [3:0]             to_cnt;
  logic [NREQ-1:0][7:0]   lanes;

  assign lanes = data_in;

  // Offsets are walked from farthest to nearest so ptr+1 overrides everything and
  // ptr itself (offset NREQ wraps to 0) is the last resort. Relies on NREQ being 2^IW.
  always_comb begin
    hit  = |req;
    pick = ptr;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[ptr + IW'(k)]) pick = ptr + IW'(k);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      ack      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      ptr      <= IW'(NREQ - 1);
      to_cnt   <= '0;
    end else begin
      tx_start <= 1'b0;
      ack      <= '0;
      case (state)
        IDLE: begin
          if (hit && tx_ready) begin
            grant   <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            tx_data <= lanes[pick];
            ptr     <= pick;
            busy    <= 1'b1;
            state   <= START;
          end else begin
            grant <= '0;
          end
        end
        START: begin
          tx_start <= 1'b1;
          ack      <= grant;
          to_cnt   <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A transmitter that never drops tx_ready must not hang the arbiter.
          if (!tx_ready) begin
            state <= WAIT_DONE;
          end else if (to_cnt == 4'(BUSY_TO - 1)) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (tx_ready) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  a_ack_onehot:   assert property (@(posedge clk) disable iff (reset) $onehot0(ack));
  a_ack_start:    assert property (@(posedge clk) disable iff (reset) (ack != '0) |-> tx_start);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model that stays busy
// ten cycles per byte, or holds tx_ready high permanently when stuck is set.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  req = '0;
  logic [63:0] data_in = '0;
  logic        tx_ready = 1'b1;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [7:0]  grant;
  logic [7:0]  ack;
  logic        busy;

  int nvec = 0;
  int nmis = 0;
  int bcnt = 0;
  logic stuck = 1'b0;
  logic [7:0] ack_q[$];
  logic [7:0] data_q[$];

  uart_tx_arbiter #(.NREQ(8), .BUSY_TO(4)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .grant(grant), .ack(ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // transmitter model
  always @(negedge clk) begin
    if (stuck) begin
      tx_ready = 1'b1;
      bcnt = 0;
    end else if (tx_start) begin
      tx_ready = 1'b0;
      bcnt = 10;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) tx_ready = 1'b1;
    end
  end

  // monitor: log every launch and the ack/byte that came with it
  always @(negedge clk) begin
    if (!reset) begin
      chk("grant_onehot", 64'($onehot0(grant)), 64'd1);
      if (tx_start) begin
        chk("ack_vs_grant", ack, grant);
        ack_q.push_back(ack);
        data_q.push_back(tx_data);
      end else begin
        chk("ack_no_start", ack, 0);
      end
    end
  end

  task automatic clear_log();
    ack_q.delete();
    data_q.delete();
  endtask

  task automatic wait_acks(input int n, input int bound);
    int c = 0;
    while (ack_q.size() < n && c < bound) begin
      @(negedge clk); #1;
      c++;
    end
    chk("ack_wait", ack_q.size(), n);
  endtask

  task automatic wait_idle(input int bound);
    int c = 0;
    while (busy && c < bound) begin
      @(negedge clk); #1;
      c++;
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic wait_grant(input logic [7:0] exp, input int bound);
    int c = 0;
    while (grant == 0 && c < bound) begin
      @(negedge clk); #1;
      c++;
    end
    chk("grant_wait", grant, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_start"}, tx_start, 0);
    chk({tag, "_data"}, tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all_zero("rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] e;
    #2;
    chk_all_zero("por");
    @(negedge clk);
    reset = 1'b0;
    #1;

    // single request from requester 0
    req = 8'h01;
    data_in[7:0] = 8'h41;
    wait_grant(8'h01, 10);
    chk("t1_start_lat", tx_start, 0);
    chk("t1_data", tx_data, 8'h41);
    chk("t1_busy", busy, 1);
    @(negedge clk); #1;
    chk("t1_start", tx_start, 1);
    chk("t1_ack", ack, 8'h01);
    req = 8'h00;
    @(negedge clk); #1;
    chk("t1_start_once", tx_start, 0);
    chk("t1_ack_once", ack, 0);
    wait_idle(100);
    chk("t1_grant_clr", grant, 0);

    // all requesters held: fresh rotation from 0
    do_reset();
    clear_log();
    for (int i = 0; i < 8; i++) data_in[8*i +: 8] = 8'h30 + 8'(i);
    req = 8'hFF;
    wait_acks(9, 400);
    req = 8'h00;
    for (int i = 0; i < 9 && i < ack_q.size(); i++) begin
      e = 8'h01 << (i % 8);
      chk("t2_order", ack_q[i], e);
      chk("t2_data", data_q[i], 8'h30 + 8'(i % 8));
    end
    wait_idle(100);
    chk("t2_starts", ack_q.size(), 9);

    // ptr moved to 2, then 7 beats 2
    clear_log();
    req = 8'h04;
    wait_acks(1, 50);
    req = 8'h00;
    wait_idle(100);
    clear_log();
    req = 8'h84;
    wait_acks(2, 100);
    req = 8'h00;
    if (ack_q.size() >= 2) begin
      chk("t3_first", ack_q[0], 8'h80);
      chk("t3_second", ack_q[1], 8'h04);
    end
    wait_idle(100);

    // latched byte survives the requester withdrawing
    data_in[31:24] = 8'hA5;
    req = 8'h08;
    wait_grant(8'h08, 10);
    req = 8'h00;
    data_in[31:24] = 8'h5A;
    @(negedge clk); #1;
    chk("t4_ack", ack, 8'h08);
    chk("t4_start", tx_start, 1);
    chk("t4_data", tx_data, 8'hA5);
    @(negedge clk); #1;
    chk("t4_data_hold", tx_data, 8'hA5);
    wait_idle(100);

    // transmitter never drops tx_ready: timeout after 4 cycles
    stuck = 1'b1;
    @(negedge clk); #1;
    data_in[15:8] = 8'h77;
    data_in[39:32] = 8'h99;
    req = 8'h02;
    wait_grant(8'h02, 10);
    @(negedge clk); #1;
    chk("t5_start", tx_start, 1);
    req = 8'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("t5_busy_hold", busy, 1);
    end
    @(negedge clk); #1;
    chk("t5_busy_fall", busy, 0);
    chk("t5_grant_clr", grant, 0);
    @(negedge clk); #1;
    chk("t5_next_grant", grant, 8'h10);
    chk("t5_next_data", tx_data, 8'h99);
    req = 8'h00;
    wait_idle(100);
    stuck = 1'b0;
    @(negedge clk); #1;

    // reset in WAIT_DONE, then rotation restarts at 0
    clear_log();
    req = 8'h20;
    wait_acks(1, 50);
    req = 8'h00;
    @(negedge clk); #1;
    chk("t6_mid_busy", busy, 1);
    chk("t6_mid_grant", grant, 8'h20);
    reset = 1'b1;
    #1;
    chk_all_zero("t6_async");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_log();
    @(negedge clk); #1;
    chk("t6_no_spurious", ack_q.size(), 0);
    data_in[7:0] = 8'h11;
    data_in[63:56] = 8'h17;
    req = 8'h81;
    wait_acks(2, 100);
    req = 8'h00;
    if (ack_q.size() >= 2) begin
      chk("t6_first", ack_q[0], 8'h01);
      chk("t6_first_data", data_q[0], 8'h11);
      chk("t6_second", ack_q[1], 8'h80);
      chk("t6_second_data", data_q[1], 8'h17);
    end
    wait_idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
